// File: rtl/aes_dg_pkg.sv
// Shared definitions for the AES block data generator: mode codes, FSM states,
// PRBS tap positions and default widths.
package aes_dg_pkg;

    localparam int DG_DATA_W = 128;
    localparam int DG_CNT_W  = 16;
    localparam int TAG_W     = 16;

    typedef enum logic [1:0] {
        MODE_INC   = 2'b00,
        MODE_PRBS  = 2'b01,
        MODE_CONST = 2'b10,
        MODE_WALK  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Feedback taps of x^128 + x^127 + x^126 + x^121 + 1, as bit positions of data_q.
    localparam int PRBS_TAP_A = 127;
    localparam int PRBS_TAP_B = 126;
    localparam int PRBS_TAP_C = 125;
    localparam int PRBS_TAP_D = 120;

    // Shift-based modes never leave the all-zero state, so a zero seed is replaced by 1.
    function automatic logic seed_needs_fixup(input mode_e m);
        return (m == MODE_PRBS) || (m == MODE_WALK);
    endfunction

endpackage

// File: rtl/aes_dg_next.sv
// Combinational successor of a generator block for each of the four modes.
module aes_dg_next
    import aes_dg_pkg::*;
#(
    parameter int DATA_W = DG_DATA_W
) (
    input  mode_e             mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic prbs_fb;

    assign prbs_fb = data_i[PRBS_TAP_A] ^ data_i[PRBS_TAP_B]
                   ^ data_i[PRBS_TAP_C] ^ data_i[PRBS_TAP_D];

    always_comb begin
        data_o = data_i;
        case (mode_i)
            MODE_INC:   data_o = data_i + DATA_W'(1);
            MODE_PRBS:  data_o = {data_i[DATA_W-2:0], prbs_fb};
            MODE_CONST: data_o = data_i;
            MODE_WALK:  data_o = {data_i[DATA_W-2:0], data_i[DATA_W-1]};
            default:    data_o = data_i;
        endcase
    end

endmodule

// File: rtl/aes_blk_datagen.sv
// Programmed-length 128-bit block generator feeding the AES input FIFO.
// Optional block-index tag in the top 16 data bits: define AES_DATAGEN_SEQ_TAG_EN.
module aes_blk_datagen
    import aes_dg_pkg::*;
#(
    parameter int DATA_W = DG_DATA_W,
    parameter int CNT_W  = DG_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic [DATA_W-1:0] seed,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  blk_cnt
);

    state_e            state_q;
    mode_e             mode_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] seed_fix;
    mode_e             mode_in;
    logic              wr_fire;
    logic              last_wr;

    assign mode_in  = mode_e'(mode);
    assign seed_fix = (seed_needs_fixup(mode_in) && (seed == '0)) ? DATA_W'(1) : seed;

    // Write strobe is decoded from the state register so reset removes it at once.
    assign wr_fire = (state_q == ST_RUN) && !fifo_full;
    assign cnt_d   = cnt_q + CNT_W'(1);
    assign last_wr = wr_fire && (cnt_d == num_q);

    aes_dg_next #(
        .DATA_W (DATA_W)
    ) u_next (
        .mode_i (mode_q),
        .data_i (data_q),
        .data_o (data_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_INC;
            num_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (num_blocks != '0) begin
                            state_q <= ST_RUN;
                            mode_q  <= mode_in;
                            num_q   <= num_blocks;
                            data_q  <= seed_fix;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (wr_fire) begin
                        data_q <= data_d;
                        cnt_q  <= cnt_d;
                    end
                    // A stop that coincides with the final write still yields one DONE.
                    if (stop || last_wr) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_wr_en = wr_fire;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign blk_cnt    = cnt_q;

`ifdef AES_DATAGEN_SEQ_TAG_EN
    logic [TAG_W-1:0] tag;
    assign tag       = TAG_W'(cnt_q);
    assign fifo_data = {tag, data_q[DATA_W-TAG_W-1:0]};
`else
    assign fifo_data = data_q;
`endif

endmodule

// File: tb/tb_aes_blk_datagen.sv
// Randomized self-checking bench for aes_blk_datagen against a sequence-level reference model.
module tb_aes_blk_datagen;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic [1:0]   mode;
    logic [15:0]  num_blocks;
    logic [127:0] seed;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [127:0] fifo_data;
    logic         busy;
    logic         done;
    logic [15:0]  blk_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_blk_datagen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .num_blocks (num_blocks),
        .seed       (seed),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .done       (done),
        .blk_cnt    (blk_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference successor: arithmetic increment, LFSR polynomial, constant, rotation.
    function automatic logic [127:0] ref_next(input logic [1:0] m, input logic [127:0] v);
        logic [127:0] taps;
        taps = '0;
        taps[127] = 1'b1; taps[126] = 1'b1; taps[125] = 1'b1; taps[120] = 1'b1;
        case (m)
            2'd0:    return v + 128'd1;
            2'd1:    return (v << 1) | 128'(^(v & taps));
            2'd2:    return v;
            default: return (v << 1) | (v >> 127);
        endcase
    endfunction

    function automatic logic [127:0] ref_data(input int idx, input logic [127:0] v);
        logic [15:0] t;
        t = 16'(idx);
`ifdef AES_DATAGEN_SEQ_TAG_EN
        return {t, v[111:0]};
`else
        if (t == 16'hffff) return '1;
        return v;
`endif
    endfunction

    task automatic build_seq(input logic [1:0] m, input logic [127:0] s, input int n,
                             output logic [127:0] q[$]);
        logic [127:0] v;
        q = {};
        v = ((m == 2'd1 || m == 2'd3) && s == '0) ? 128'd1 : s;
        for (int i = 0; i < n; i++) begin
            q.push_back(v);
            v = ref_next(m, v);
        end
    endtask

    task automatic launch(input logic [1:0] m, input logic [127:0] s, input int n);
        @(posedge clk); #1;
        start = 1'b1; mode = m; num_blocks = 16'(n); seed = s;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the sampled-at-start inputs to prove they were latched.
        mode = 2'($urandom_range(0, 3));
        num_blocks = 16'($urandom);
        seed = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic expect_done(input int cnt);
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'd1);
        chk("done_busy", 128'(busy), 128'd0);
        chk("done_wren", 128'(fifo_wr_en), 128'd0);
        chk("done_cnt", 128'(blk_cnt), 128'(cnt));
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_done", 128'(done), 128'd0);
        chk("hold_cnt", 128'(blk_cnt), 128'(cnt));
    endtask

    // stop_at: raise stop in the cycle where this many blocks have been written (-1 = never).
    task automatic run_job(input logic [1:0] m, input logic [127:0] s, input int n,
                           input int full_pct, input int stop_at);
        logic [127:0] q[$];
        int  wr;
        int  cyc;
        bit  fin;
        bit  stopped;
        build_seq(m, s, n, q);
        launch(m, s, n);
        wr = 0; cyc = 0; fin = (n == 0); stopped = 1'b0;
        while (!fin && cyc < 2000) begin
            fifo_full = ($urandom_range(0, 99) < full_pct);
            stop      = (stop_at >= 0 && wr == stop_at);
            start     = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            chk("run_busy", 128'(busy), 128'd1);
            chk("run_done", 128'(done), 128'd0);
            chk("run_wren", 128'(fifo_wr_en), 128'(!fifo_full));
            chk("run_cnt", 128'(blk_cnt), 128'(wr));
            if (!fifo_full) begin
                chk("run_data", fifo_data, ref_data(wr, q[wr]));
                wr++;
            end
            stopped = stop;
            fin = (wr == n) || stopped;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; stop = 1'b0; fifo_full = 1'b0;
        if (!fin) chk("job_timeout", 128'd0, 128'd1);
        expect_done(wr);
        $display("job mode=%0d num=%0d full_pct=%0d stop_at=%0d writes=%0d", m, n, full_pct, stop_at, wr);
    endtask

    // Bounded FIFO of depth 7 driving fifo_full from its occupancy.
    task automatic fifo_job();
        int occ, wr, cyc, stall, reads_left;
        bit rd;
        occ = 0; wr = 0; cyc = 0; stall = 0; reads_left = 3;
        launch(2'd0, 128'd0, 10);
        while (wr < 10 && cyc < 200) begin
            fifo_full = (occ >= 7);
            @(negedge clk);
            chk("ff_wren", 128'(fifo_wr_en), 128'(occ < 7));
            if (fifo_wr_en) begin
                chk("ff_data", fifo_data, ref_data(wr, 128'(wr)));
                wr++;
            end else begin
                stall++;
            end
            rd = (stall >= 4) && (reads_left > 0);
            @(posedge clk); #1;
            if (fifo_wr_en) occ++;
            if (rd) begin occ--; reads_left--; end
            if (occ > 7) chk("ff_overflow", 128'(occ), 128'd7);
            cyc++;
        end
        fifo_full = 1'b0;
        chk("ff_writes", 128'(wr), 128'd10);
        chk("ff_stalled", 128'(stall >= 4), 128'd1);
        expect_done(10);
        $display("job fifo num=10 writes=%0d stall_cycles=%0d", wr, stall);
    endtask

    task automatic reset_mid_run();
        launch(2'd0, 128'd0, 100);
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_wren", 128'(fifo_wr_en), 128'd1);
        rst = 1'b0;
        #1;
        chk("rst_wren", 128'(fifo_wr_en), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_cnt", 128'(blk_cnt), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_data", fifo_data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", 128'(done), 128'd0);
            chk("post_rst_wren", 128'(fifo_wr_en), 128'd0);
        end
        $display("job reset_mid_run");
    endtask

    initial begin
        logic [1:0]   m;
        logic [127:0] s;
        int           n;
        rst = 1'b0; start = 1'b0; stop = 1'b0; mode = '0;
        num_blocks = '0; seed = '0; fifo_full = 1'b0;
        @(negedge clk);
        chk("reset_wren", 128'(fifo_wr_en), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_cnt", 128'(blk_cnt), 128'd0);
        chk("reset_data", fifo_data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_job(2'd0, 128'd0, 5, 0, -1);
        fifo_job();
        run_job(2'd1, 128'd0, 3, 0, -1);
        run_job(2'd3, {1'b1, 127'd0}, 2, 0, -1);
        run_job(2'd0, '1, 2, 0, -1);
        run_job(2'd0, 128'd7, 0, 0, -1);
        run_job(2'd0, 128'd9, 100, 0, 4);
        run_job(2'd2, 128'd0, 3, 0, -1);
        reset_mid_run();

        for (int j = 0; j < 30; j++) begin
            m = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       s = '0;
                1:       s = '1;
                default: s = {$urandom, $urandom, $urandom, $urandom};
            endcase
            n = $urandom_range(0, 12);
            run_job(m, s, n, $urandom_range(0, 70),
                    ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
